// File: rtl/atom_ps2_keymatrix_pkg.sv
// atom_kbd_pkg: shared definitions for the Atom PS/2 key-matrix slice.
//   - PS/2 scancode constants for the prefix and control bytes
//   - key_desc_t: lookup result {valid, is_mod, mod_id, row, col}
//   - kbd_lookup(): the {ext,code} -> matrix/modifier table
//   - odd_parity_ok(): PS/2 frame parity check
// For modifiers, mod_id selects the function (shift/ctrl/rept/break).
// col[0] selects which physical key of that function was pressed.
package atom_kbd_pkg;

  localparam logic [7:0] SC_REL    = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_ERR1   = 8'hFF;

  typedef enum logic [1:0] {
    MOD_SHIFT = 2'd0,
    MOD_CTRL  = 2'd1,
    MOD_REPT  = 2'd2,
    MOD_BREAK = 2'd3
  } mod_e;

  typedef struct packed {
    logic       valid;
    logic       is_mod;
    logic [1:0] mod_id;
    logic [3:0] row;
    logic [2:0] col;
  } key_desc_t;

  // Odd parity over the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  function automatic key_desc_t mk_key(input logic [3:0] row, input logic [2:0] col);
    return '{valid: 1'b1, is_mod: 1'b0, mod_id: 2'd0, row: row, col: col};
  endfunction

  function automatic key_desc_t mk_mod(input mod_e id, input logic phys);
    return '{valid: 1'b1, is_mod: 1'b1, mod_id: id, row: 4'd0, col: {2'b00, phys}};
  endfunction

  function automatic key_desc_t kbd_lookup(input logic ext, input logic [7:0] code);
    key_desc_t d;
    case ({ext, code})
      9'h029:  d = mk_key(4'd9, 3'd0);        // SPACE
      9'h01C:  d = mk_key(4'd1, 3'd5);        // A
      9'h032:  d = mk_key(4'd2, 3'd5);        // B
      9'h021:  d = mk_key(4'd3, 3'd5);        // C
      9'h023:  d = mk_key(4'd4, 3'd5);        // D
      9'h024:  d = mk_key(4'd5, 3'd5);        // E
      9'h02B:  d = mk_key(4'd6, 3'd5);        // F
      9'h016:  d = mk_key(4'd6, 3'd2);        // 1
      9'h01E:  d = mk_key(4'd5, 3'd2);        // 2
      9'h026:  d = mk_key(4'd4, 3'd2);        // 3
      9'h05A:  d = mk_key(4'd6, 3'd1);        // RETURN
      9'h066:  d = mk_key(4'd4, 3'd1);        // DELETE
      9'h175:  d = mk_key(4'd3, 3'd1);        // UP
      9'h174:  d = mk_key(4'd2, 3'd1);        // RIGHT
      9'h012:  d = mk_mod(MOD_SHIFT, 1'b0);   // LSHIFT
      9'h059:  d = mk_mod(MOD_SHIFT, 1'b1);   // RSHIFT
      9'h014:  d = mk_mod(MOD_CTRL,  1'b0);   // LCTRL
      9'h114:  d = mk_mod(MOD_CTRL,  1'b1);   // RCTRL
      9'h011:  d = mk_mod(MOD_REPT,  1'b0);   // LALT -> REPT
      9'h007:  d = mk_mod(MOD_BREAK, 1'b0);   // F12 -> BREAK
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/atom_ps2_keymatrix_if.sv
// atom_ps2_keymatrix_if: PS/2 line and PIA-side signals of the key matrix.
//   ps2_clk/ps2_data : raw keyboard lines (master -> slave)
//   row              : PIA Port A[3:0] row select (master -> slave)
//   col_n            : PIA Port B[5:0] columns, low = pressed
//   ctrl_n/shift_n   : PIA Port B[6]/[7]
//   rept_n           : PIA Port C[6]
//   break_n          : to the system reset generator
//   key_event        : one-cycle pulse on any key state change
interface atom_ps2_keymatrix_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] row;
  logic [5:0] col_n;
  logic       ctrl_n;
  logic       shift_n;
  logic       rept_n;
  logic       break_n;
  logic       key_event;

  modport slave (
    input  ps2_clk, ps2_data, row,
    output col_n, ctrl_n, shift_n, rept_n, break_n, key_event
  );

  modport master (
    output ps2_clk, ps2_data, row,
    input  col_n, ctrl_n, shift_n, rept_n, break_n, key_event
  );
endinterface

// File: rtl/atom_ps2_keymatrix_ps2_rx.sv
// ps2_rx: PS/2 device-to-host byte receiver.
//   clk, reset       : system clock, async active-high reset
//   i_ps2_clk/data   : raw asynchronous PS/2 lines
//   o_byte           : last accepted byte
//   o_byte_valid     : one-cycle strobe, the cycle after the stop-bit sample
// A frame is dropped on bad parity, a low stop bit, or TIMEOUT_CYCLES
// without a falling edge while mid-frame.
module ps2_rx
  import atom_kbd_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_valid
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_clk_prev;
  rx_state_e              r_state;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_shift;
  logic                   r_par;
  logic [TW-1:0]          r_tmo;
  logic [7:0]             r_byte;
  logic                   r_byte_valid;
  logic                   w_fall;
  logic                   w_data;

  assign w_data = r_data_sync[SYNC_STAGES-1];
  assign w_fall = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];

  // Synchronise both lines; reset to the idle-high level so no false edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_sync  <= {SYNC_STAGES{1'b1}};
      r_data_sync <= {SYNC_STAGES{1'b1}};
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_ps2_data};
      r_clk_prev  <= r_clk_sync[SYNC_STAGES-1];
    end
  end

  // Receive FSM with timeout; a falling edge takes priority over the timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= 3'd0;
      r_shift      <= 8'h00;
      r_par        <= 1'b0;
      r_tmo        <= '0;
      r_byte       <= 8'h00;
      r_byte_valid <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      if (w_fall) begin
        r_tmo <= '0;
        case (r_state)
          ST_IDLE: begin
            r_bit_cnt <= 3'd0;
            r_state   <= w_data ? ST_IDLE : ST_DATA;
          end
          ST_DATA: begin
            r_shift <= {w_data, r_shift[7:1]};
            if (r_bit_cnt == 3'd7) begin
              r_state <= ST_PARITY;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
          ST_PARITY: begin
            r_par   <= w_data;
            r_state <= ST_STOP;
          end
          ST_STOP: begin
            if (w_data && odd_parity_ok(r_shift, r_par)) begin
              r_byte       <= r_shift;
              r_byte_valid <= 1'b1;
            end
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end else if (r_state != ST_IDLE) begin
        if (r_tmo == TMO_LAST) begin
          r_state <= ST_IDLE;
          r_tmo   <= '0;
        end else begin
          r_tmo <= r_tmo + 1'b1;
        end
      end else begin
        r_tmo <= '0;
      end
    end
  end

  assign o_byte       = r_byte;
  assign o_byte_valid = r_byte_valid;

endmodule

// File: rtl/atom_ps2_keymatrix.sv
// atom_ps2_keymatrix: PS/2 keyboard to Acorn Atom 10x6 key matrix.
//   clk, reset : system clock, async active-high reset
//   bus        : atom_ps2_keymatrix_if.slave
//     - PS/2 lines in
//     - row select in
//     - col_n/ctrl_n/shift_n/rept_n/break_n/key_event out
// Decodes make/break codes into held-key state. The PIA reads columns
// combinationally from that state through the row select.
module atom_ps2_keymatrix
  import atom_kbd_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int NUM_ROWS       = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  atom_ps2_keymatrix_if.slave  bus
);

  localparam logic [3:0] ROWS_L = 4'(NUM_ROWS);

  logic [7:0]                w_byte;
  logic                      w_byte_valid;
  key_desc_t                 w_desc;
  logic [NUM_ROWS-1:0][5:0]  r_matrix;
  logic [NUM_ROWS-1:0][5:0]  w_matrix_nxt;
  // Held modifiers indexed {mod_id, physical key}.
  logic [7:0]                r_mod;
  logic [7:0]                w_mod_nxt;
  logic                      r_ext, r_rel, w_ext_nxt, w_rel_nxt;
  logic [2:0]                r_skip, w_skip_nxt;
  logic                      r_key_event;

  ps2_rx #(
    .SYNC_STAGES    (SYNC_STAGES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk          (clk),
    .reset        (reset),
    .i_ps2_clk    (bus.ps2_clk),
    .i_ps2_data   (bus.ps2_data),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid)
  );

  assign w_desc = kbd_lookup(r_ext, w_byte);

  // Next key/prefix state for the byte being strobed this cycle.
  always_comb begin
    w_matrix_nxt = r_matrix;
    w_mod_nxt    = r_mod;
    w_ext_nxt    = r_ext;
    w_rel_nxt    = r_rel;
    w_skip_nxt   = r_skip;
    if (w_byte_valid && (r_skip != 3'd0)) begin
      w_skip_nxt = r_skip - 3'd1;
    end else if (w_byte_valid) begin
      case (w_byte)
        SC_REL:   w_rel_nxt  = 1'b1;
        SC_EXT:   w_ext_nxt  = 1'b1;
        SC_PAUSE: w_skip_nxt = 3'd7;
        SC_BAT: begin
          w_matrix_nxt = '0;
          w_mod_nxt    = 8'h00;
          w_ext_nxt    = 1'b0;
          w_rel_nxt    = 1'b0;
        end
        SC_ACK, SC_ECHO, SC_RESEND, SC_ERR0, SC_ERR1: w_skip_nxt = r_skip;
        default: begin
          if (w_desc.valid && w_desc.is_mod) begin
            w_mod_nxt[{w_desc.mod_id, w_desc.col[0]}] = ~r_rel;
          end else if (w_desc.valid && (w_desc.row < ROWS_L)) begin
            w_matrix_nxt[w_desc.row][w_desc.col] = ~r_rel;
          end else begin
            w_mod_nxt = r_mod;
          end
          w_ext_nxt = 1'b0;
          w_rel_nxt = 1'b0;
        end
      endcase
    end else begin
      w_skip_nxt = r_skip;
    end
  end

  // Commit decoder state; key_event flags only real state changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_matrix    <= '0;
      r_mod       <= 8'h00;
      r_ext       <= 1'b0;
      r_rel       <= 1'b0;
      r_skip      <= 3'd0;
      r_key_event <= 1'b0;
    end else begin
      r_matrix    <= w_matrix_nxt;
      r_mod       <= w_mod_nxt;
      r_ext       <= w_ext_nxt;
      r_rel       <= w_rel_nxt;
      r_skip      <= w_skip_nxt;
      r_key_event <= (w_matrix_nxt != r_matrix) || (w_mod_nxt != r_mod);
    end
  end

  // Zero-latency PIA read path; unpopulated rows read as all released.
  always_comb begin
    if (bus.row < ROWS_L) begin
      bus.col_n = ~r_matrix[bus.row];
    end else begin
      bus.col_n = 6'h3F;
    end
  end

  assign bus.shift_n   = ~|r_mod[1:0];
  assign bus.ctrl_n    = ~|r_mod[3:2];
  assign bus.rept_n    = ~|r_mod[5:4];
  assign bus.break_n   = ~|r_mod[7:6];
  assign bus.key_event = r_key_event;

endmodule

// File: doc/atom_ps2_keymatrix.md
Name: atom_ps2_keymatrix

Overview:
Converts a PS/2 keyboard byte stream into the Atom 10x6 key matrix plus SHIFT, CTRL, REPT and BREAK.
- Feeds the PIA: the row select comes from PIA Port A bits 3:0, and the column result drives PIA Port B.
- Also drives REPT into Port C bit 6.
- The CPU scans the matrix by software. This block maintains matrix state from make/break codes and answers row queries combinationally.

Parameters:
- SYNC_STAGES, 2: synchroniser depth on ps2_clk and ps2_data.
- TIMEOUT_CYCLES, 50000: clk cycles without a PS/2 falling edge before a partial frame is discarded.
- NUM_ROWS, 10: populated matrix rows.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_data  in  1  raw PS/2 data, asynchronous.
- row  in  4  row select from PIA Port A[3:0].
- col_n  out  6  column bits for PIA Port B[5:0], low = pressed.
- ctrl_n  out  1  Port B[6], low while CTRL is held.
- shift_n  out  1  Port B[7], low while either SHIFT is held.
- rept_n  out  1  Port C[6], low while REPT is held.
- break_n  out  1  low while BREAK is held; goes to the system reset generator.
- key_event  out  1  one-cycle pulse on every matrix or modifier change (debug/IRQ).

Behaviour:
- Reset is asynchronous and active-high on clk.
  - All matrix bits released.
  - col_n=6'h3F; ctrl_n=shift_n=rept_n=break_n=1; key_event=0.
  - Receiver in IDLE, prefix flags cleared.
- Sync: ps2_clk and ps2_data each pass through SYNC_STAGES flops. Falling edge = previous synced clk 1, current 0.
- Receiver FSM (sub-module), sampling on each falling edge:
  - IDLE: a start bit of 0 goes to DATA; a 1 stays in IDLE.
  - DATA: shift in 8 bits LSB first, bit counter 0..7, then PARITY.
  - PARITY: capture the bit, then STOP.
  - STOP: byte is accepted only if stop=1 and the 9 bits have odd parity. Then emit byte_valid for exactly one clk, 1 cycle after the stop-bit sample. Return to IDLE either way.
  - Timeout: counter clears on each falling edge. In any non-IDLE state, reaching TIMEOUT_CYCLES-1 forces IDLE and drops the byte.
  - A falling edge in the same cycle as the timeout: the edge wins.
- Decoder, acting on byte_valid:
  - F0: set rel.
  - E0: set ext.
  - E1: set skip=7; the next 7 bytes are ignored (Pause key).
  - AA: clear all matrix and modifier state (keyboard BAT); clear flags.
  - FA, EE, FE, 00, FF: ignored; flags unchanged.
  - Any other byte: look up {ext,code}.
    - A matrix key sets bit [r][c] to !rel.
    - A modifier sets its own held bit to !rel.
    - An unmapped code changes nothing.
    - Always clear ext and rel afterwards.
  - Releasing a key that was not pressed leaves it released, with no key_event.
  - key_event pulses only when a state bit actually changes, in the cycle after byte_valid.
- Modifiers are tracked per physical key:
  - shift_n = !(LSHIFT 12 | RSHIFT 59).
  - ctrl_n = !(LCTRL 14 | E0 14).
  - rept_n = !(LALT 11).
  - break_n = !(F12 07).
- Output mapping:
  - col_n = ~matrix[row] when row < NUM_ROWS; otherwise 6'h3F.
  - Purely combinational from row and registered state (zero latency). The PIA read path is combinational.
- Auto-repeat make codes for an already-pressed key cause no change and no key_event.

Decomposition:
- Package atom_kbd_pkg holds:
  - scancode constants;
  - the key descriptor type {valid, is_mod, mod_id[1:0], row[3:0], col[2:0]};
  - function kbd_lookup(ext, code) returning the descriptor. This table is authoritative.
- Entries the bench uses:
  - 29 SPACE -> r9 c0.
  - 1C A -> r1 c5.
  - 16 1 -> r6 c2.
  - E0 75 UP -> r3 c1.
- Sub-module ps2_rx holds the synchroniser, receive FSM and timeout. Its outputs are byte[7:0] and byte_valid.

Test Plan:
- Frame 1C, then F0 1C, with row=1 -> col_n=3F→1F after the first frame; 1F→3F after the F0 1C; key_event pulses twice.
- Press 1C with row=0 and row=12 -> col_n=3F in both cases; row=1 gives 1F.
- Frame 1C with a bad parity bit, then a frame truncated after 4 data bits followed by TIMEOUT_CYCLES idle, then a valid 29 -> only r9 c0 is pressed (row=9 col_n=3E); 1C never registers.
- Press 12 and 59, release 12 -> shift_n stays 0; release 59 -> shift_n=1. Press E0 14 -> ctrl_n=0; F0 14 (no E0) -> ctrl_n stays 0.
- Press 1C, 29, 07, then byte AA -> all col_n=3F and break_n=1; key_event pulses once.
- Press 1C, assert reset mid-frame of the next byte -> all outputs at reset values. A frame completed after reset is decoded normally.
